// File: rtl/redondeo_pkg.sv
// Shared definitions for the redondeo narrowing blocks: rounding-mode
// encodings and the helper that turns a mode into the pre-shift increment.
package redondeo_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_TRUNC     = 2'd0;
  localparam mode_t MODE_HALF_UP   = 2'd1;
  localparam mode_t MODE_HALF_EVEN = 2'd2;

  // Increment added before dropping 'drop' fraction bits. keep_lsb is the
  // lowest bit that survives the shift; it breaks ties toward even.
  // The reserved encoding behaves like truncation.
  function automatic int round_inc(input int drop, input mode_t mode,
                                   input logic keep_lsb);
    int half;
    half = 1 << (drop - 1);
    case (mode)
      MODE_HALF_UP:   return half;
      MODE_HALF_EVEN: return half - 1 + int'(keep_lsb);
      default:        return 0;
    endcase
  endfunction

endpackage

// File: rtl/redondeo_sat.sv
// Combinational shift + clamp: takes a rounded sum, drops DROP fraction bits
// (arithmetic) and saturates the result into a signed OUT_W-bit word.
module redondeo_sat #(
  parameter int SUM_W = 12,
  parameter int DROP  = 4,
  parameter int OUT_W = 6
) (
  input  logic [SUM_W-1:0] sum,
  output logic [OUT_W-1:0] data,
  output logic             ovf_pos,
  output logic             ovf_neg
);

  localparam int Q_W = SUM_W - DROP;

  // Arithmetic shift right by DROP is just the top Q_W bits of the sum.
  logic [Q_W-1:0]       q;
  logic [Q_W-OUT_W:0]   hi;
  logic                 fits;
  logic [DROP-1:0]      unused_frac;

  assign q           = sum[SUM_W-1:DROP];
  assign unused_frac = sum[DROP-1:0];
  assign hi          = q[Q_W-1:OUT_W-1];
  // The value fits when every bit above the output sign bit copies it.
  assign fits        = (&hi) | ~(|hi);

  // Clamp to the signed range of the output word and flag the direction.
  always_comb begin
    data    = q[OUT_W-1:0];
    ovf_pos = 1'b0;
    ovf_neg = 1'b0;
    if (!fits) begin
      if (q[Q_W-1]) begin
        data    = {1'b1, {(OUT_W-1){1'b0}}};
        ovf_neg = 1'b1;
      end else begin
        data    = {1'b0, {(OUT_W-1){1'b1}}};
        ovf_pos = 1'b1;
      end
    end
  end

endmodule

// File: rtl/redondeo_pipe.sv
// Two-stage rounding/saturating narrower with valid/ready handshake.
// Stage 1 adds the mode-dependent rounding increment, stage 2 shifts,
// clamps and registers the result with its overflow flags.
// Optional saturation-event counter: define REDONDEO_STATS_EN.
module redondeo_pipe
  import redondeo_pkg::*;
#(
  parameter int IN_W     = 11,
  parameter int IN_FRAC  = 4,
  parameter int OUT_W    = 6,
  parameter int OUT_FRAC = 0,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf_pos,
  output logic             out_ovf_neg,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] sat_count
);

  localparam int DROP  = IN_FRAC - OUT_FRAC;
  localparam int SUM_W = IN_W + 1;

  if (DROP < 1 || (IN_W - DROP) < (OUT_W - 1)) begin : g_bad_params
    $error("redondeo_pipe: need DROP>=1 and IN_W-DROP >= OUT_W-1");
  end

  // Handshake: a sample moves on a cycle where valid and ready are both
  // high at the rising edge. The whole pipe advances together when the
  // output slot is empty or being taken, so in_ready depends only on
  // out_valid/out_ready, never on in_valid. A held output stays stable.
  logic en;
  assign en       = !out_valid | out_ready;
  assign in_ready = en;

  logic [SUM_W-1:0] inc;
  logic [SUM_W-1:0] sum_next;
  logic             s1_valid;
  logic [SUM_W-1:0] s1_sum;

  // One extra bit of headroom so a rounding carry out of max positive
  // is seen by the clamp instead of wrapping.
  assign inc      = SUM_W'(round_inc(DROP, mode_t'(in_mode), in_data[DROP]));
  assign sum_next = {in_data[IN_W-1], in_data} + inc;

  // Stage 1: register the rounded-up sum and its valid bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) s1_sum <= sum_next;
    end
  end

  logic [OUT_W-1:0] sat_data;
  logic             sat_pos;
  logic             sat_neg;

  redondeo_sat #(
    .SUM_W (SUM_W),
    .DROP  (DROP),
    .OUT_W (OUT_W)
  ) u_sat (
    .sum     (s1_sum),
    .data    (sat_data),
    .ovf_pos (sat_pos),
    .ovf_neg (sat_neg)
  );

  // Stage 2: register clamped data and flags together with out_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_ovf_pos <= 1'b0;
      out_ovf_neg <= 1'b0;
    end else if (en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data    <= sat_data;
        out_ovf_pos <= sat_pos;
        out_ovf_neg <= sat_neg;
      end
    end
  end

`ifdef REDONDEO_STATS_EN
  logic sat_xfer;
  assign sat_xfer = out_valid & out_ready & (out_ovf_pos | out_ovf_neg);

  // Count delivered saturated samples; sticks at all-ones, clear wins.
  always_ff @(posedge clk) begin
    if (reset || clr_cnt) begin
      sat_count <= '0;
    end else if (sat_xfer && (sat_count != {CNT_W{1'b1}})) begin
      sat_count <= sat_count + 1'b1;
    end
  end
`else
  logic unused_clr;
  assign unused_clr = clr_cnt;
  assign sat_count  = '0;
`endif

endmodule

// File: tb/tb_redondeo_pipe.sv
// Self-checking bench for redondeo_pipe: driver pushes expected results
// from an arithmetic reference model into a queue, a monitor pops and
// compares on every output transfer.
module tb_redondeo_pipe;

  localparam int IN_W     = 11;
  localparam int IN_FRAC  = 4;
  localparam int OUT_W    = 6;
  localparam int OUT_FRAC = 0;
`ifdef REDONDEO_STATS_EN
  localparam int CNT_W    = 2;
`else
  localparam int CNT_W    = 8;
`endif
  localparam int DROP     = IN_FRAC - OUT_FRAC;
  localparam int EXP_W    = OUT_W + 2;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_ovf_pos;
  logic             out_ovf_neg;
  logic             clr_cnt;
  logic [CNT_W-1:0] sat_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic             started = 1'b0;

  redondeo_pipe #(
    .IN_W(IN_W), .IN_FRAC(IN_FRAC), .OUT_W(OUT_W),
    .OUT_FRAC(OUT_FRAC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ovf_pos(out_ovf_pos),
    .out_ovf_neg(out_ovf_neg), .clr_cnt(clr_cnt), .sat_count(sat_count)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Value x / 2^DROP rounded per mode, then clamped: {pos, neg, data}.
  function automatic logic [EXP_W-1:0] ref_round(input int x, input int mode);
    int scale, half, fl, r, q, maxv, minv;
    logic [EXP_W-1:0] res;
    scale = 1 << DROP;
    half  = scale / 2;
    fl    = floor_div(x, scale);
    r     = x - fl * scale;
    case (mode)
      1:       q = (r >= half) ? fl + 1 : fl;
      2: begin
        if (r > half)      q = fl + 1;
        else if (r < half) q = fl;
        else               q = ((fl & 1) != 0) ? fl + 1 : fl;
      end
      default: q = fl;
    endcase
    maxv = (1 << (OUT_W - 1)) - 1;
    minv = -(1 << (OUT_W - 1));
    if (q > maxv)      res = {2'b10, OUT_W'(maxv)};
    else if (q < minv) res = {2'b01, OUT_W'(minv)};
    else               res = {2'b00, OUT_W'(q)};
    return res;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called aligned just after a rising edge; returns aligned likewise.
  task automatic send(input int x, input int m);
    int waited;
    in_valid = 1'b1;
    in_data  = IN_W'(x);
    in_mode  = 2'(m);
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: in_ready stuck low for sample %0d", x);
    end else begin
      exp_q.push_back(ref_round(x, m));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic             prev_stall = 1'b0;
  logic [EXP_W-1:0] prev_item;
  logic [CNT_W-1:0] model_cnt = '0;

  initial begin
    logic [EXP_W-1:0] got, want;
    logic             flagged;
    forever begin
      @(negedge clk);
      if (started) begin
        check("sat_count", 32'(sat_count), 32'(model_cnt));
      end
      flagged = 1'b0;
      if (reset || !started) begin
        prev_stall = 1'b0;
      end else begin
        got = {out_ovf_pos, out_ovf_neg, out_data};
        if (prev_stall) begin
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_hold", 32'(got), 32'(prev_item));
        end
        if (out_valid && !out_ready) begin
          check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_output: got %0h with empty queue", got);
            flagged = out_ovf_pos | out_ovf_neg;
          end else begin
            want = exp_q.pop_front();
            check("result", 32'(got), 32'(want));
            flagged = want[EXP_W-1] | want[EXP_W-2];
          end
        end
        prev_stall = out_valid & !out_ready;
        prev_item  = got;
      end
      // counter model for the coming edge
`ifdef REDONDEO_STATS_EN
      if (reset || clr_cnt)                  model_cnt = '0;
      else if (flagged && model_cnt != '1)   model_cnt = model_cnt + 1'b1;
`else
      model_cnt = '0;
`endif
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    bit done;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = '0;
    out_ready = 1'b0;
    clr_cnt   = 1'b0;
    idle(3);
    reset   = 1'b0;
    started = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_ovf_pos", 32'(out_ovf_pos), 32'd0);
    check("rst_ovf_neg", 32'(out_ovf_neg), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // latency with an empty pipe and out_ready high
    out_ready = 1'b1;
    send(234, 1);
    @(negedge clk);
    check("latency_cycle1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("latency_cycle2", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;

    // directed values: rounding, saturation, carry into overflow, ties
    send(234, 0);   send(-101, 1); send(-101, 0);
    send(525, 1);   send(-600, 1); send(504, 1);  send(503, 1);
    send(40, 2);    send(56, 2);   send(-40, 2);  send(234, 3);
    send(-1024, 1); send(1023, 2); send(-24, 2);  send(-8, 1);
    drain();

    // back-to-back stream with a 3-cycle stall in the middle
    fork
      begin
        send(100, 1); send(200, 2); send(-300, 0);
        send(17, 1);  send(-5, 2);  send(511, 1);
      end
      begin
        idle(2);
        out_ready = 1'b0;
        idle(3);
        out_ready = 1'b1;
      end
    join
    drain();

    // reset with samples in flight: nothing may come out afterwards
    out_ready = 1'b0;
    send(300, 1);
    send(-300, 2);
    reset = 1'b1;
    exp_q.delete();
    idle(1);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("midrst_flushed", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

`ifdef REDONDEO_STATS_EN
    // counter sticks at its maximum
    for (int i = 0; i < 5; i++) send(525, 1);
    drain();
    check("cnt_saturated", 32'(sat_count), 32'd3);
    // clear coinciding with a saturating transfer
    clr_cnt = 1'b1;
    send(-600, 1);
    @(negedge clk);
    @(negedge clk);
    check("clr_xfer_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    @(negedge clk);
    check("cnt_clr_wins", 32'(sat_count), 32'd0);
    @(posedge clk);
    #1;
`endif

    // randomized traffic with bubbles, backpressure and counter clears
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          n = $urandom_range(0, 3);
          if (n == 0) idle($urandom_range(1, 2));
          begin
            logic signed [IN_W-1:0] ds;
            ds = IN_W'($urandom_range(0, (1 << IN_W) - 1));
            send(int'(ds), $urandom_range(0, 3));
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          clr_cnt   = ($urandom_range(0, 31) == 0);
          idle(1);
        end
        out_ready = 1'b1;
        clr_cnt   = 1'b0;
      end
    join
    drain();
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // global time bound
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

endmodule
